r4_seq_ctrl: RTL and testbench

Sequencer for the radix-4 butterfly datapath. It accepts one block of four complex samples over a valid/ready handshake and holds them on the butterfly's sample inputs. It then steps the butterfly control lines (c1, c2, c3) through four output codes, one per cycle, and registers each combinational result (Xro, Xio) into a back-pressured output stream tagged with its output index. It sits between the sample source and the downstream stage, and the butterfly instance sits beside it.

---
 rtl/r4_pkg.sv | 15 +
 rtl/r4_ctrl_rom.sv | 13 +
 rtl/r4_seq_ctrl.sv | 109 ++++++++++
 tb/tb_r4_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r4_pkg.sv
// Shared definitions for the radix-4 butterfly sequencer: default width,
// controller state encoding and the k -> {c1,c2,c3} control-code table.
package r4_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Indexed by output index k; bit order is {c1,c2,c3}.
  localparam logic [2:0] CTRL_CODE [0:3] = '{3'b000, 3'b110, 3'b011, 3'b101};

endpackage

// File: rtl/r4_ctrl_rom.sv
// Decodes the butterfly output index k into the {c1,c2,c3} control code.
// Forces the all-zero code while the caller is not driving a block.
module r4_ctrl_rom
  import r4_pkg::*;
(
  input  logic       i_en,
  input  logic [1:0] i_k,
  output logic [2:0] o_code
);

  assign o_code = i_en ? CTRL_CODE[i_k] : 3'b000;

endmodule

// File: rtl/r4_seq_ctrl.sv
// Radix-4 butterfly sequencer: holds one accepted block on the butterfly inputs,
// steps k through 0..3 and registers each result into a back-pressured stream.
module r4_seq_ctrl
  import r4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WIDTH-1:0] in_xr,
  input  logic [4*WIDTH-1:0] in_xi,
  output logic [4*WIDTH-1:0] bf_xr,
  output logic [4*WIDTH-1:0] bf_xi,
  output logic               bf_c1,
  output logic               bf_c2,
  output logic               bf_c3,
  input  logic [WIDTH-1:0]   bf_xro,
  input  logic [WIDTH-1:0]   bf_xio,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_re,
  output logic [WIDTH-1:0]   out_im,
  output logic [1:0]         out_idx,
  output logic               out_last,
  output logic [7:0]         blk_cnt
);

  state_t             r_state;
  logic [1:0]         r_k;
  logic [4*WIDTH-1:0] r_xr;
  logic [4*WIDTH-1:0] r_xi;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_re;
  logic [WIDTH-1:0]   r_out_im;
  logic [1:0]         r_out_idx;
  logic               r_out_last;
  logic [7:0]         r_blk_cnt;

  logic               w_busy;
  logic               w_advance;
  logic               w_last_step;
  logic               w_accept;
  logic [2:0]         w_code;

  assign w_busy      = (r_state == ST_BUSY);
  // Capture whenever the output register is empty or being drained this edge.
  assign w_advance   = w_busy && (!r_out_valid || out_ready);
  assign w_last_step = w_advance && (r_k == 2'd3);
  assign in_ready    = rst_n && (!w_busy || w_last_step);
  assign w_accept    = in_valid && in_ready;

  r4_ctrl_rom u_ctrl_rom (
    .i_en   (w_busy),
    .i_k    (r_k),
    .o_code (w_code)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_k         <= 2'd0;
      r_xr        <= '0;
      r_xi        <= '0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_idx   <= 2'd0;
      r_out_last  <= 1'b0;
      r_blk_cnt   <= 8'd0;
    end else begin
      if (w_advance) begin
        r_out_re    <= bf_xro;
        r_out_im    <= bf_xio;
        r_out_idx   <= r_k;
        r_out_last  <= (r_k == 2'd3);
        r_out_valid <= 1'b1;
        if (r_k == 2'd3) begin
          r_blk_cnt <= r_blk_cnt + 8'd1;
          r_k       <= 2'd0;
          r_state   <= ST_IDLE;
        end else begin
          r_k <= r_k + 2'd1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      // A block accepted on the final capture edge overrides the return to IDLE.
      if (w_accept) begin
        r_xr    <= in_xr;
        r_xi    <= in_xi;
        r_k     <= 2'd0;
        r_state <= ST_BUSY;
      end
    end
  end

  assign bf_xr                 = r_xr;
  assign bf_xi                 = r_xi;
  assign {bf_c1, bf_c2, bf_c3} = w_code;
  assign out_valid             = r_out_valid;
  assign out_re                = r_out_re;
  assign out_im                = r_out_im;
  assign out_idx               = r_out_idx;
  assign out_last              = r_out_last;
  assign blk_cnt               = r_blk_cnt;

endmodule

// File: tb/tb_r4_seq_ctrl.sv
// Bench for r4_seq_ctrl: behavioural butterfly beside the controller, directed
// scenarios followed by randomized traffic checked against a queue-based model.
module tb_r4_seq_ctrl;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] in_xr, in_xi;
  logic [4*W-1:0] bf_xr, bf_xi;
  logic           bf_c1, bf_c2, bf_c3;
  logic [W-1:0]   bf_xro, bf_xio;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_re, out_im;
  logic [1:0]     out_idx;
  logic           out_last;
  logic [7:0]     blk_cnt;

  always #5 clk = ~clk;

  r4_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_xr(in_xr), .in_xi(in_xi), .bf_xr(bf_xr), .bf_xi(bf_xi),
    .bf_c1(bf_c1), .bf_c2(bf_c2), .bf_c3(bf_c3),
    .bf_xro(bf_xro), .bf_xio(bf_xio),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
    .out_last(out_last), .blk_cnt(blk_cnt)
  );

  // Multiply (a + jb) by j^m.
  function automatic int rot_re(int m, int a, int b);
    case (m)
      0: return a;
      1: return -b;
      2: return -a;
      default: return b;
    endcase
  endfunction

  function automatic int rot_im(int m, int a, int b);
    case (m)
      0: return b;
      1: return a;
      2: return -b;
      default: return -a;
    endcase
  endfunction

  // Butterfly stand-in: per-sample rotation chosen by the control code.
  function automatic int bfly_rot(logic [2:0] code, int n);
    case (code)
      3'b110: case (n) 0: return 2; 1: return 3; 2: return 0; default: return 1; endcase
      3'b011: case (n) 0: return 0; 1: return 2; 2: return 0; default: return 2; endcase
      3'b101: case (n) 0: return 0; 1: return 3; 2: return 2; default: return 1; endcase
      default: return 0;
    endcase
  endfunction

  always_comb begin
    int sr, si, m;
    sr = 0;
    si = 0;
    m  = 0;
    for (int n = 0; n < 4; n++) begin
      m  = bfly_rot({bf_c1, bf_c2, bf_c3}, n);
      sr = sr + rot_re(m, int'(bf_xr[n*W +: W]), int'(bf_xi[n*W +: W]));
      si = si + rot_im(m, int'(bf_xr[n*W +: W]), int'(bf_xi[n*W +: W]));
    end
    bf_xro = sr[W-1:0];
    bf_xio = si[W-1:0];
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [1:0]   idx;
    logic         last;
  } word_t;

  word_t          held_q[$];
  word_t          m_out;
  logic           m_ovalid;
  logic [7:0]     m_blk;
  int             m_done;
  int             m_accepts;
  logic [4*W-1:0] m_xr, m_xi;
  int             n_checks = 0;
  int             n_fail   = 0;

  function automatic logic [2:0] code_of(int k);
    case (k)
      1: return 3'b110;
      2: return 3'b011;
      3: return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // Expected result k: sum of x_n rotated by j^(k*n), negated for k=1.
  function automatic word_t expect_word(int k, logic [4*W-1:0] xr, logic [4*W-1:0] xi);
    word_t w;
    int sr, si, m;
    sr = 0;
    si = 0;
    for (int n = 0; n < 4; n++) begin
      m  = (k * n + ((k == 1) ? 2 : 0)) % 4;
      sr = sr + rot_re(m, int'(xr[n*W +: W]), int'(xi[n*W +: W]));
      si = si + rot_im(m, int'(xr[n*W +: W]), int'(xi[n*W +: W]));
    end
    w.re   = W'(sr & MASK);
    w.im   = W'(si & MASK);
    w.idx  = 2'(k);
    w.last = (k == 3);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    held_q.delete();
    m_out    = '0;
    m_ovalid = 1'b0;
    m_blk    = 8'd0;
    m_xr     = '0;
    m_xi     = '0;
  endtask

  // One clock: check at negedge+1, advance the model, cross the rising edge.
  task automatic step();
    logic adv, exp_ready, acc;
    int   k;
    #1;
    adv       = (held_q.size() > 0) && (!m_ovalid || out_ready);
    exp_ready = rst_n && ((held_q.size() == 0) || (adv && held_q.size() == 1));
    k         = (held_q.size() > 0) ? 4 - held_q.size() : 0;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(m_ovalid));
    chk("out_re", 32'(out_re), 32'(m_out.re));
    chk("out_im", 32'(out_im), 32'(m_out.im));
    chk("out_idx", 32'(out_idx), 32'(m_out.idx));
    chk("out_last", 32'(out_last), 32'(m_out.last));
    chk("bf_c", 32'({bf_c1, bf_c2, bf_c3}), 32'((held_q.size() > 0) ? code_of(k) : 3'b000));
    chk("bf_xr", 32'(bf_xr), 32'(m_xr));
    chk("bf_xi", 32'(bf_xi), 32'(m_xi));
    chk("blk_cnt", 32'(blk_cnt), 32'(m_blk));
    if (!rst_n) begin
      model_reset();
    end else begin
      acc = in_valid && exp_ready;
      if (adv) begin
        m_out    = held_q.pop_front();
        m_ovalid = 1'b1;
        if (m_out.last) begin
          m_blk = m_blk + 8'd1;
          m_done++;
        end
      end else if (m_ovalid && out_ready) begin
        m_ovalid = 1'b0;
      end
      if (acc) begin
        m_xr = in_xr;
        m_xi = in_xi;
        for (int kk = 0; kk < 4; kk++) held_q.push_back(expect_word(kk, in_xr, in_xi));
        m_accepts++;
        $display("block %0d accepted xr=%h xi=%h at %0t", m_accepts, in_xr, in_xi, $time);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  int   cyc;
  int   seen;
  logic [7:0] blk_before;

  initial begin
    m_done    = 0;
    m_accepts = 0;
    model_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_xr     = 16'h4321;
    in_xi     = '0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset held with a block offered.
    step();
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();

    // Single block (1,2,3,4) with free-flowing output.
    in_valid = 1'b1;
    in_xr    = 16'h4321;
    in_xi    = '0;
    step();
    in_valid = 1'b0;
    step();
    chk("dir_re0", 32'(out_re), 32'd10);
    chk("dir_im0", 32'(out_im), 32'd0);
    step();
    chk("dir_re1", 32'(out_re), 32'd2);
    chk("dir_im1", 32'(out_im), 32'd2);
    for (int i = 0; i < 4; i++) step();
    chk("dir_blk1", 32'(blk_cnt), 32'd1);

    // Backpressure: stall 3 cycles after idx0 appears.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("bp_c_held", 32'({bf_c1, bf_c2, bf_c3}), 32'(3'b110));
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Back-to-back: two blocks offered continuously.
    blk_before = m_blk;
    seen = m_accepts;
    in_valid = 1'b1;
    cyc = 0;
    while (m_accepts < seen + 2 && cyc < 20) begin
      in_xr = 16'(($urandom));
      in_xi = 16'(($urandom));
      step();
      cyc++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("b2b_blk", 32'(blk_cnt), 32'(blk_before + 8'd2));

    // Reset during the idx2 capture edge.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_blk", 32'(blk_cnt), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    step();

    // Randomized traffic until the block counter has wrapped.
    m_done = 0;
    cyc = 0;
    while (m_done < 260 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_xr     = 16'(($urandom));
      in_xi     = 16'(($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    chk("rand_budget", 32'(cyc < 20000), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("rand_drained", 32'(held_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
